neuron_step_mac: RTL and testbench

- Downstream consumer of the 16-phase step sequencer. Receives the sequencer's 5-bit phase index and enable.
- Each enabled phase multiplies one signed input sample by a per-phase weight held in a local 16-entry weight file, and accumulates the product.
- After phase 15 the block emits one scaled, saturated neuron output with a one-cycle valid pulse.

---
 rtl/neuron_pkg.sv | 30 +++
 rtl/neuron_weight_rf.sv | 31 +++
 rtl/neuron_step_mac.sv | 142 ++++++++++++++
 tb/tb_neuron_step_mac.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state type, phase constants, default widths and saturation helper
package neuron_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int NUM_STEPS = 16;
    localparam int LAST_STEP = NUM_STEPS - 1;

    localparam int DEF_DW    = 8;
    localparam int DEF_ACCW  = 2 * DEF_DW + 4;
    localparam int DEF_SHIFT = 4;

    // Clamp a sign-extended value to the signed range of a dw-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/neuron_weight_rf.sv
// rtl/neuron_weight_rf.sv - 16-entry signed weight file, synchronous write, combinational read
module neuron_weight_rf
    import neuron_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [3:0]           i_waddr,
    input  logic signed [DW-1:0] i_wdata,
    input  logic [3:0]           i_raddr,
    output logic signed [DW-1:0] o_rdata
);

    logic signed [DW-1:0] r_mem [NUM_STEPS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/neuron_step_mac.sv
// rtl/neuron_step_mac.sv - 16-phase weighted MAC neuron; NEURON_RELU_EN clamps negative results to 0
module neuron_step_mac
    import neuron_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACCW  = 2 * DW + 4,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_step_en,
    input  logic [4:0]           i_step,
    input  logic signed [DW-1:0] i_data_in,
    input  logic                 i_w_we,
    input  logic [3:0]           i_w_addr,
    input  logic signed [DW-1:0] i_w_data,
    output logic signed [DW-1:0] o_data_out,
    output logic                 o_out_valid,
    output logic                 o_busy,
    output logic                 o_seq_err
);

    state_t                 r_state;
    state_t                 w_state_nx;
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] w_acc_nx;
    logic [3:0]             r_exp;
    logic [3:0]             w_exp_nx;
    logic                   w_err_set;
    logic                   w_fire;
    logic signed [DW-1:0]   r_data_out;
    logic                   r_out_valid;
    logic                   r_seq_err;

    logic signed [DW-1:0]   w_weight;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_shifted;
    logic signed [DW-1:0]   w_sat;
    logic signed [DW-1:0]   w_result;

    neuron_weight_rf #(
        .DW(DW)
    ) u_weight_rf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (i_w_we),
        .i_waddr (i_w_addr),
        .i_wdata (i_w_data),
        .i_raddr (i_step[3:0]),
        .o_rdata (w_weight)
    );

    assign w_prod     = i_data_in * w_weight;
    assign w_prod_ext = ACCW'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shifted  = w_sum >>> SHIFT;
    assign w_sat      = DW'(saturate(64'(w_shifted), DW));

`ifdef NEURON_RELU_EN
    assign w_result = w_sat[DW-1] ? '0 : w_sat;
`else
    assign w_result = w_sat;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_exp_nx   = r_exp;
        w_err_set  = 1'b0;
        w_fire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_step_en) begin
                    if (i_step == 5'd0) begin
                        w_acc_nx   = w_prod_ext;
                        w_exp_nx   = 4'd1;
                        w_state_nx = ST_RUN;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // r_exp is never 0 in RUN, so the in-order check cannot shadow a restart.
                if (!i_step_en) begin
                    w_acc_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else if (i_step == {1'b0, r_exp}) begin
                    if (r_exp == 4'(LAST_STEP)) begin
                        w_fire     = 1'b1;
                        w_acc_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_acc_nx = w_sum;
                        w_exp_nx = r_exp + 4'd1;
                    end
                end else if (i_step == 5'd0) begin
                    w_acc_nx  = w_prod_ext;
                    w_exp_nx  = 4'd1;
                    w_err_set = 1'b1;
                end else begin
                    w_acc_nx   = '0;
                    w_err_set  = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_exp       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_exp       <= w_exp_nx;
            r_out_valid <= w_fire;
            if (w_fire) begin
                r_data_out <= w_result;
            end
            if (w_err_set) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign o_data_out  = r_data_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state == ST_RUN);
    assign o_seq_err   = r_seq_err;

endmodule

// File: tb/tb_neuron_step_mac.sv
// tb/tb_neuron_step_mac.sv - table-driven and directed-sequence bench for neuron_step_mac
module tb_neuron_step_mac;

    logic              clk = 1'b0;
    logic              rst;
    logic              step_en;
    logic [4:0]        step;
    logic signed [7:0] data_in;
    logic              w_we;
    logic [3:0]        w_addr;
    logic signed [7:0] w_data;
    logic signed [7:0] data_out;
    logic              out_valid;
    logic              busy;
    logic              seq_err;

    int n_vec  = 0;
    int n_fail = 0;

    neuron_step_mac dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_step_en   (step_en),
        .i_step      (step),
        .i_data_in   (data_in),
        .i_w_we      (w_we),
        .i_w_addr    (w_addr),
        .i_w_data    (w_data),
        .o_data_out  (data_out),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wt;
        int din;
        int expv;
    } vec_t;

    vec_t vecs [13];

    function automatic int relu(input int v);
`ifdef NEURON_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_w(input int val);
        for (int i = 0; i < 16; i++) begin
            w_we   = 1'b1;
            w_addr = 4'(i);
            w_data = 8'(val);
            tick();
        end
        w_we = 1'b0;
    endtask

    task automatic drive_phase(input int p, input int din);
        step_en = 1'b1;
        step    = 5'(p);
        data_in = 8'(din);
        tick();
    endtask

    // Runs phases 0..15, then checks the one-cycle result pulse.
    task automatic run_frame(input int din, input int expv, input string name);
        for (int p = 0; p < 16; p++) begin
            drive_phase(p, din);
            if (p < 15) check({name, "_novalid"}, int'(out_valid), 0);
        end
        step_en = 1'b0;
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_data"}, int'(data_out), expv);
        tick();
        check({name, "_pulse1"}, int'(out_valid), 0);
        check({name, "_hold"}, int'(data_out), expv);
    endtask

    initial begin
        vecs[0]  = '{1,    16,   16};
        vecs[1]  = '{127,  127,  127};
        vecs[2]  = '{127,  -128, relu(-128)};
        vecs[3]  = '{-1,   16,   relu(-16)};
        vecs[4]  = '{2,    3,    6};
        vecs[5]  = '{0,    100,  0};
        vecs[6]  = '{1,    -1,   relu(-1)};
        vecs[7]  = '{3,    -5,   relu(-15)};
        vecs[8]  = '{1,    127,  127};
        vecs[9]  = '{1,    -128, relu(-128)};
        vecs[10] = '{2,    64,   127};
        vecs[11] = '{-1,   -128, 127};
        vecs[12] = '{1,    7,    7};

        rst = 1'b0; step_en = 1'b0; step = '0; data_in = '0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        @(negedge clk);
        do_reset();
        check("rst_data_out", int'(data_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_seq_err", int'(seq_err), 0);

        // Weights start at zero after reset.
        run_frame(50, 0, "zero_w");

        for (int i = 0; i < 13; i++) begin
            load_w(vecs[i].wt);
            run_frame(vecs[i].din, vecs[i].expv, $sformatf("vec%0d", i));
        end
        check("no_seq_err_after_table", int'(seq_err), 0);

        // Abort after phase 7, then a clean frame must not see leftovers.
        load_w(1);
        for (int p = 0; p < 8; p++) drive_phase(p, 16);
        check("abort_busy_mid", int'(busy), 1);
        step_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_no_valid", int'(out_valid), 0);
        end
        check("abort_busy_low", int'(busy), 0);
        check("abort_no_err", int'(seq_err), 0);
        run_frame(16, 16, "after_abort");

        // Back-to-back: phase 0 of the next frame in the out_valid cycle.
        for (int p = 0; p < 16; p++) drive_phase(p, 16);
        check("b2b_valid", int'(out_valid), 1);
        check("b2b_data", int'(data_out), 16);
        drive_phase(0, 32);
        check("b2b_pulse1", int'(out_valid), 0);
        check("b2b_busy", int'(busy), 1);
        for (int p = 1; p < 16; p++) drive_phase(p, 32);
        step_en = 1'b0;
        check("b2b_valid2", int'(out_valid), 1);
        check("b2b_data2", int'(data_out), 32);
        tick();

        // Write to index 4 during its own accept: old weight used now, new weight next frame.
        for (int p = 0; p < 16; p++) begin
            if (p == 4) begin
                w_we = 1'b1; w_addr = 4'd4; w_data = 8'sd2;
            end
            drive_phase(p, 16);
            w_we = 1'b0;
        end
        step_en = 1'b0;
        check("wr_same_valid", int'(out_valid), 1);
        check("wr_same_data", int'(data_out), 16);
        tick();
        run_frame(16, 17, "wr_next");

        // Restart at phase 0 mid-frame: seq_err set, new frame only.
        for (int p = 0; p < 6; p++) drive_phase(p, 16);
        drive_phase(0, 16);
        check("restart_err", int'(seq_err), 1);
        check("restart_busy", int'(busy), 1);
        for (int p = 1; p < 16; p++) drive_phase(p, 16);
        step_en = 1'b0;
        check("restart_valid", int'(out_valid), 1);
        check("restart_data", int'(data_out), 17);
        tick();

        // Out-of-order phase: 3 while expecting 5.
        do_reset();
        check("oor_err_cleared", int'(seq_err), 0);
        load_w(1);
        for (int p = 0; p < 5; p++) drive_phase(p, 16);
        drive_phase(3, 16);
        check("oor_err", int'(seq_err), 1);
        check("oor_idle", int'(busy), 0);
        check("oor_no_valid", int'(out_valid), 0);
        step_en = 1'b0;
        tick(); tick();
        check("oor_sticky", int'(seq_err), 1);
        run_frame(16, 16, "after_oor");
        check("oor_sticky2", int'(seq_err), 1);

        // Nonzero phase in IDLE, and step > 15 in RUN.
        do_reset();
        load_w(1);
        drive_phase(7, 16);
        check("idle_bad_err", int'(seq_err), 1);
        check("idle_bad_busy", int'(busy), 0);
        do_reset();
        load_w(1);
        drive_phase(0, 16);
        drive_phase(17, 16);
        check("step_gt15_err", int'(seq_err), 1);
        check("step_gt15_idle", int'(busy), 0);

        // Reset at phase 10 wipes everything, including weights.
        do_reset();
        load_w(1);
        run_frame(32, 32, "pre_rst");
        for (int p = 0; p < 10; p++) drive_phase(p, 16);
        rst = 1'b1;
        drive_phase(10, 16);
        rst = 1'b0;
        step_en = 1'b0;
        check("midrst_data", int'(data_out), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_err", int'(seq_err), 0);
        run_frame(16, 0, "midrst_zero_w");
        load_w(1);
        run_frame(16, 16, "midrst_fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
